// File: rtl/fetch_align_pkg.sv
// fetch_align_pkg: shared widths and the RVC length test for the fetch front end
package fetch_align_pkg;
    localparam int ILEN = 32;
    localparam int HW = 16;
    typedef logic [HW-1:0] hw_t;
    function automatic logic is_rvc(input logic [1:0] lo);
        return lo != 2'b11;
    endfunction
endpackage

// File: rtl/fetch_align_hw_queue.sv
// fetch_align_hw_queue: 3-entry halfword shift queue, push 0-2 and pop 0-2 per cycle, flush
module fetch_align_hw_queue
    import fetch_align_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        flush_i,
    input  logic [1:0]  push_i,
    input  logic [31:0] din_i,
    input  logic [1:0]  pop_i,
    output logic [1:0]  count_o,
    output hw_t         hw0_o,
    output hw_t         hw1_o
);
    hw_t e_q [3];
    hw_t e_d [3];
    hw_t sh [3];
    logic [1:0] cnt_q, rem;

    // pop shifts survivors to the head, then pushes land right behind them
    always_comb begin
        rem = cnt_q - pop_i;
        sh[0] = pop_i == 2'd2 ? e_q[2] : pop_i == 2'd1 ? e_q[1] : e_q[0];
        sh[1] = pop_i == 2'd0 ? e_q[1] : pop_i == 2'd1 ? e_q[2] : '0;
        sh[2] = pop_i == 2'd0 ? e_q[2] : '0;
        for (int i = 0; i < 3; i++)
            e_d[i] = (push_i != 2'd0 && 2'(i) == rem) ? din_i[15:0]
                   : (push_i == 2'd2 && 2'(i) == rem + 2'd1) ? din_i[31:16] : sh[i];
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
            e_q <= '{default: '0};
        end else begin
            cnt_q <= flush_i ? 2'd0 : rem + push_i;
            e_q <= e_d;
        end
    end

    assign count_o = cnt_q;
    assign hw0_o = e_q[0];
    assign hw1_o = e_q[1];
endmodule

// File: rtl/fetch_align.sv
// fetch_align: word fetch over valid/ready, realigned into 16/32-bit instructions with PC
module fetch_align
    import fetch_align_pkg::*;
#(
    parameter int XLEN = 32,
    parameter logic [XLEN-1:0] RESET = '0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ILEN-1:0] out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic            out_rvc
);
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, head_pc_q, head_pc_d;
    logic pending_q, pending_d, kill_q, kill_d, drop_lo_q, drop_lo_d;
    logic [1:0] count, push, pop, need;
    logic [2:0] proj;
    logic [ILEN-1:0] push_data;
    logic rsp_live, is32, fire, req_fire;
    hw_t hw0, hw1;

    fetch_align_hw_queue u_q (
        .clock   (clock),
        .reset   (reset),
        .flush_i (redirect),
        .push_i  (push),
        .din_i   (push_data),
        .pop_i   (pop),
        .count_o (count),
        .hw0_o   (hw0),
        .hw1_o   (hw1)
    );

    // a response landing in a redirect cycle is stale and never enters the queue
    always_comb begin
        rsp_live = imem_rsp_valid && !kill_q && !redirect;
        push = rsp_live ? (drop_lo_q ? 2'd1 : 2'd2) : 2'd0;
        push_data = drop_lo_q ? {16'h0, imem_rsp_data[31:16]} : imem_rsp_data;
        is32 = !is_rvc(hw0[1:0]);
        need = is32 ? 2'd2 : 2'd1;
        out_valid = !redirect && count >= need;
        fire = out_valid && out_ready;
        pop = fire ? need : 2'd0;
        proj = 3'(count) + 3'(push) - 3'(pop);
        imem_req_valid = reset && !redirect && (!pending_q || imem_rsp_valid) && proj <= 3'd1;
        req_fire = imem_req_valid && imem_req_ready;
        pending_d = req_fire || (pending_q && !imem_rsp_valid);
        kill_d = redirect ? pending_q && !imem_rsp_valid : kill_q && !imem_rsp_valid;
        drop_lo_d = redirect ? redirect_pc[1] : drop_lo_q && !rsp_live;
        fetch_pc_d = redirect ? redirect_pc & ~XLEN'(3) : req_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
        head_pc_d = redirect ? redirect_pc & ~XLEN'(1)
                  : fire ? head_pc_q + (is32 ? XLEN'(4) : XLEN'(2)) : head_pc_q;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            fetch_pc_q <= RESET & ~XLEN'(3);
            head_pc_q <= RESET;
            pending_q <= 1'b0;
            kill_q <= 1'b0;
            drop_lo_q <= RESET[1];
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q <= head_pc_d;
            pending_q <= pending_d;
            kill_q <= kill_d;
            drop_lo_q <= drop_lo_d;
        end
    end

    assign imem_req_addr = fetch_pc_q;
    assign out_pc = head_pc_q;
    assign out_inst = is32 ? {hw1, hw0} : {16'h0, hw0};
    assign out_rvc = count != 2'd0 && !is32;
endmodule

// File: tb/tb_fetch_align.sv
// tb_fetch_align: directed scenarios against an instruction-stream model and a memory responder
module tb_fetch_align;
    localparam logic [31:0] RST_PC = 32'h0;

    logic clock = 0, reset = 0, redirect = 0, imem_req_ready = 1, imem_rsp_valid = 0, out_ready = 1;
    logic [31:0] redirect_pc = 0, imem_rsp_data = 0;
    logic imem_req_valid, out_valid, out_rvc;
    logic [31:0] imem_req_addr, out_inst, out_pc;

    fetch_align #(.XLEN(32), .RESET(RST_PC)) dut (
        .clock          (clock),
        .reset          (reset),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_rvc        (out_rvc)
    );

    always #5 clock = ~clock;

    typedef struct { int cyc; logic [31:0] pc; logic [31:0] inst; logic rvc; } out_t;
    typedef struct { int cyc; logic [31:0] addr; } req_t;
    out_t out_log[$];
    req_t req_log[$];
    int rsp_log[$];
    logic [31:0] mem [256];
    int cyc = 0, base = 0, lat = 1, n_cmp = 0, n_bad = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc - base);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'b0, act}, {31'b0, exp});
    endtask

    function automatic logic [15:0] hw_at(input logic [31:0] a);
        logic [31:0] w;
        w = mem[a[9:2]];
        return a[1] ? w[31:16] : w[15:0];
    endfunction

    // memory: one slot, response exactly lat cycles after acceptance, reset along with the DUT
    initial begin : memory
        logic slot_v;
        logic [31:0] slot_a;
        int slot_n;
        slot_v = 0;
        slot_a = 0;
        slot_n = 0;
        forever begin
            @(negedge clock);
            if (imem_rsp_valid) begin
                slot_v = 0;
                rsp_log.push_back(cyc);
            end
            if (!reset) slot_v = 0;
            else if (imem_req_valid && imem_req_ready) begin
                chk1("one_outstanding", slot_v, 1'b0);
                slot_v = 1;
                slot_a = imem_req_addr;
                slot_n = lat;
            end
            @(posedge clock);
            #1;
            imem_rsp_valid = 0;
            imem_rsp_data = 32'hbad0_bad0;
            if (slot_v) begin
                slot_n--;
                if (slot_n == 0) begin
                    imem_rsp_valid = 1;
                    imem_rsp_data = mem[slot_a[9:2]];
                end
            end
        end
    end

    // model: the instruction stream at exp_pc decoded straight from memory, sequential word requests
    initial begin : model
        logic [31:0] exp_pc, exp_req, h_pc, h_inst, e_inst;
        logic [15:0] lo;
        logic h_rvc, held, e_rvc;
        out_t o;
        req_t r;
        exp_pc = RST_PC;
        exp_req = RST_PC & ~32'd3;
        held = 0;
        h_pc = 0; h_inst = 0; h_rvc = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_pc = RST_PC;
                exp_req = RST_PC & ~32'd3;
                held = 0;
            end else begin
                if (held && !redirect) begin
                    chk1("hold_valid", out_valid, 1'b1);
                    chk("hold_pc", out_pc, h_pc);
                    chk("hold_inst", out_inst, h_inst);
                    chk1("hold_rvc", out_rvc, h_rvc);
                end
                held = 0;
                if (redirect) begin
                    chk1("redirect_no_out", out_valid, 1'b0);
                    chk1("redirect_no_req", imem_req_valid, 1'b0);
                    exp_pc = redirect_pc & ~32'd1;
                    exp_req = redirect_pc & ~32'd3;
                end else begin
                    if (imem_req_valid && imem_req_ready) begin
                        chk("req_addr", imem_req_addr, exp_req);
                        r.cyc = cyc; r.addr = imem_req_addr;
                        req_log.push_back(r);
                        exp_req += 4;
                    end
                    if (out_valid && out_ready) begin
                        lo = hw_at(exp_pc);
                        e_rvc = lo[1:0] != 2'b11;
                        e_inst = e_rvc ? {16'h0, lo} : {hw_at(exp_pc + 2), lo};
                        chk("out_pc", out_pc, exp_pc);
                        chk("out_inst", out_inst, e_inst);
                        chk1("out_rvc", out_rvc, e_rvc);
                        o.cyc = cyc; o.pc = out_pc; o.inst = out_inst; o.rvc = out_rvc;
                        out_log.push_back(o);
                        exp_pc += e_rvc ? 2 : 4;
                    end else if (out_valid) begin
                        held = 1;
                        h_pc = out_pc; h_inst = out_inst; h_rvc = out_rvc;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic fill();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013 | (32'(i) << 7);
    endtask

    task automatic start();
        reset = 0;
        redirect = 0;
        out_ready = 1;
        tick(1);
        @(negedge clock);
        chk1("rst_req_valid", imem_req_valid, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk("rst_req_addr", imem_req_addr, RST_PC & ~32'd3);
        chk("rst_out_pc", out_pc, RST_PC);
        chk("rst_out_inst", out_inst, 32'h0);
        chk1("rst_out_rvc", out_rvc, 1'b0);
        tick(1);
        reset = 1;
        base = cyc;
        out_log.delete();
        req_log.delete();
        rsp_log.delete();
    endtask

    initial begin : main
        logic [31:0] w;
        // 32-bit stream, 1-cycle memory: one instruction every 2 cycles
        fill();
        lat = 1;
        start();
        tick(8);
        chk1("s1_nreq", req_log.size() >= 3, 1'b1);
        chk1("s1_nout", out_log.size() >= 3, 1'b1);
        if (req_log.size() >= 3 && out_log.size() >= 3)
            for (int k = 0; k < 3; k++) begin
                chk("s1_req_addr", req_log[k].addr, 4 * k);
                chk("s1_req_cyc", req_log[k].cyc - base, 2 * k);
                chk("s1_out_pc", out_log[k].pc, 4 * k);
                chk("s1_out_cyc", out_log[k].cyc - base, 2 * k + 2);
                chk1("s1_out_rvc", out_log[k].rvc, 1'b0);
            end
        // two RVC in one word
        fill();
        mem[0] = 32'h4505_4501;
        start();
        tick(6);
        chk1("s2_nout", out_log.size() >= 2, 1'b1);
        if (out_log.size() >= 2) begin
            chk("s2_pc0", out_log[0].pc, 32'h0);
            chk("s2_inst0", out_log[0].inst, 32'h0000_4501);
            chk1("s2_rvc0", out_log[0].rvc, 1'b1);
            chk("s2_cyc0", out_log[0].cyc - base, 2);
            chk("s2_pc1", out_log[1].pc, 32'h2);
            chk("s2_inst1", out_log[1].inst, 32'h0000_4505);
            chk1("s2_rvc1", out_log[1].rvc, 1'b1);
            chk("s2_cyc1", out_log[1].cyc - base, 3);
        end
        // 32-bit instruction straddling two words
        fill();
        mem[0] = 32'h0513_4501;
        mem[1] = 32'h0001_00a0;
        start();
        tick(7);
        chk1("s3_nout", out_log.size() >= 2 && rsp_log.size() >= 2, 1'b1);
        if (out_log.size() >= 2 && rsp_log.size() >= 2) begin
            chk("s3_pc0", out_log[0].pc, 32'h0);
            chk("s3_inst0", out_log[0].inst, 32'h0000_4501);
            chk("s3_pc1", out_log[1].pc, 32'h2);
            chk("s3_inst1", out_log[1].inst, 32'h00a0_0513);
            chk1("s3_rvc1", out_log[1].rvc, 1'b0);
            chk1("s3_after_rsp", out_log[1].cyc > rsp_log[1], 1'b1);
            chk("s3_cyc1", out_log[1].cyc - base, 4);
        end
        // redirect to an odd halfword while a request is outstanding
        fill();
        mem[0] = 32'h4501_4501;
        mem[64] = 32'h4585_1234;
        lat = 3;
        start();
        tick(1);
        redirect = 1;
        redirect_pc = 32'h103;
        tick(1);
        redirect = 0;
        tick(12);
        lat = 1;
        chk1("s4_nlog", req_log.size() >= 2 && out_log.size() >= 1, 1'b1);
        if (req_log.size() >= 2 && out_log.size() >= 1) begin
            chk("s4_req0", req_log[0].addr, 32'h0);
            chk("s4_req1", req_log[1].addr, 32'h100);
            chk("s4_req1_cyc", req_log[1].cyc - base, 3);
            chk("s4_pc0", out_log[0].pc, 32'h102);
            chk("s4_inst0", out_log[0].inst, 32'h0000_4585);
            chk1("s4_rvc0", out_log[0].rvc, 1'b1);
            chk("s4_cyc0", out_log[0].cyc - base, 7);
        end
        // full queue held by out_ready=0, then redirect together with out_ready=1
        fill();
        mem[0] = 32'h4501_dead;
        start();
        out_ready = 0;
        redirect = 1;
        redirect_pc = 32'h2;
        tick(1);
        redirect = 0;
        tick(8);
        @(negedge clock);
        chk1("s5_hold_valid", out_valid, 1'b1);
        chk("s5_hold_pc", out_pc, 32'h2);
        chk("s5_hold_inst", out_inst, 32'h0000_4501);
        chk1("s5_no_req", imem_req_valid, 1'b0);
        chk("s5_nreq", req_log.size(), 2);
        chk("s5_nout", out_log.size(), 0);
        tick(1);
        out_ready = 1;
        redirect = 1;
        redirect_pc = 32'h200;
        tick(1);
        redirect = 0;
        tick(6);
        w = mem[128];
        chk1("s5_nout2", out_log.size() >= 1, 1'b1);
        if (out_log.size() >= 1) begin
            chk("s5_flush_pc", out_log[0].pc, 32'h200);
            chk("s5_flush_inst", out_log[0].inst, w);
        end
        // one-cycle reset in the middle of fetch
        fill();
        start();
        tick(5);
        reset = 0;
        tick(1);
        reset = 1;
        @(negedge clock);
        chk1("s6_out_valid", out_valid, 1'b0);
        chk1("s6_req_valid", imem_req_valid, 1'b1);
        chk("s6_req_addr", imem_req_addr, RST_PC & ~32'd3);
        tick(8);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
